imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_if.sv | 31 +++
 rtl/imm_encoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/imm_encoder_if.sv
// ---------------------------------------------------------------------------
// imm_encoder_if
// Groups the request and result handshake signals of imm_encoder.
//   Request side : in_valid, in_ready, in_fmt[2:0], in_imm[31:0], in_base[31:0]
//   Result side  : out_valid, out_ready, out_instr[31:0], out_err, out_last
// Modports:
//   slave  - the encoder (consumes requests, produces results)
//   master - the requester/consumer driving the encoder
// ---------------------------------------------------------------------------
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_last
  );

  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
// Inserts an immediate into a RISC-V instruction skeleton according to a
// format code, or expands a 32-bit load-immediate into LUI/ADDI words.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - imm_encoder_if.slave (request handshake + registered result)
// Formats: 000 pass, 001 I-zero, 010 I-signed, 011 S, 100 B, 101 U, 110 J,
//          111 LI expansion (one or two output words).
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit the selected format on out_err. Without it out_err is tied low.
// ---------------------------------------------------------------------------
module imm_encoder (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_LAST  = 2'd2;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic [1:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] enc_word;
  logic [31:0] enc_addi;
  logic        enc_pair;
  logic        enc_err;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic        in_ready;
  logic        accept;

  // A new request can land when empty, or when the final word leaves this cycle.
  assign in_ready     = !rst && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_LAST) && bus.out_ready));
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_last  = out_last_q;

  // ADDI sign-extends lo, so hi is pre-incremented when lo is negative.
  assign li_rd = bus.in_base[11:7];
  assign li_lo = bus.in_imm[11:0];
  assign li_hi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

  always_comb begin
    enc_word = bus.in_base;
    enc_addi = 32'd0;
    enc_pair = 1'b0;
    case (bus.in_fmt)
      3'b001, 3'b010: enc_word = {bus.in_imm[11:0], bus.in_base[19:0]};
      3'b011: enc_word = {bus.in_imm[11:5], bus.in_base[24:12],
                          bus.in_imm[4:0], bus.in_base[6:0]};
      3'b100: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_base[24:12],
                          bus.in_imm[4:1], bus.in_imm[11], bus.in_base[6:0]};
      3'b101: enc_word = {bus.in_imm[31:12], bus.in_base[11:0]};
      3'b110: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                          bus.in_imm[19:12], bus.in_base[11:0]};
      3'b111: begin
        // Second word of a pair adds lo onto the LUI result in rd.
        enc_addi = {li_lo, li_rd, 3'b000, li_rd, OP_ADDI};
        if (li_hi == 20'd0) begin
          enc_word = {li_lo, 5'd0, 3'b000, li_rd, OP_ADDI};
        end else if (li_lo == 12'd0) begin
          enc_word = {li_hi, li_rd, OP_LUI};
        end else begin
          enc_word = {li_hi, li_rd, OP_LUI};
          enc_pair = 1'b1;
        end
      end
      default: enc_word = bus.in_base;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flags immediates whose discarded upper bits are not a plain extension.
  always_comb begin
    enc_err = 1'b0;
    case (bus.in_fmt)
      3'b001:         enc_err = |bus.in_imm[31:12];
      3'b010, 3'b011: enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      3'b100:         enc_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]))
                                || bus.in_imm[0];
      3'b101:         enc_err = |bus.in_imm[11:0];
      3'b110:         enc_err = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20]))
                                || bus.in_imm[0];
      default:        enc_err = 1'b0;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  // Output-register control: FIRST swaps in the pending ADDI, LAST drains,
  // and an accept (from IDLE or a draining LAST) loads a fresh word.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    pend_d      = pend_q;
    case (state_q)
      ST_IDLE: ;
      ST_FIRST: begin
        if (bus.out_ready) begin
          out_instr_d = pend_q;
          out_err_d   = 1'b0;
          out_last_d  = 1'b1;
          state_d     = ST_LAST;
        end
      end
      ST_LAST: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_err_d   = enc_err;
      out_last_d  = !enc_pair;
      pend_d      = enc_addi;
      state_d     = enc_pair ? ST_FIRST : ST_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      pend_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      pend_q      <= pend_d;
    end
  end

endmodule
